barrel_multipass_ctrl: RTL

Sequential controller that sits directly upstream of the 16-bit barrel shifter (`in`, `lr`, `shift`, `out`) and extends its 4-bit shift range to an 8-bit shift amount. It accepts one shift request over a valid/ready handshake and drives the barrel shifter for one or more passes of at most 15 positions each. After each pass it registers the barrel output and feeds it back as the next pass's input. It then presents the final word on a valid/ready response port.

---
 rtl/barrel_pkg.sv | 15 +
 rtl/barrel_multipass_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/barrel_pkg.sv
// Shared types for the multi-pass barrel shifter controller.
package barrel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest shift a barrel with an shw-bit amount port can do in one pass.
  function automatic int unsigned max_step(input int unsigned shw);
    return (32'd1 << shw) - 32'd1;
  endfunction

endpackage

// File: rtl/barrel_multipass_ctrl.sv
// Drives an external barrel shifter for several passes so that a single request
// can shift by more than the barrel's own range, then returns the final word.
module barrel_multipass_ctrl
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4,
  parameter int unsigned AMTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_lr,
  input  logic [AMTW-1:0]  req_amt,
  output logic [WIDTH-1:0] bs_in,
  output logic             bs_lr,
  output logic [SHW-1:0]   bs_shift,
  input  logic [WIDTH-1:0] bs_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AMTW-1:0]  rsp_passes
);

  localparam int unsigned MAX_STEP = max_step(SHW);

  state_t           state, state_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [AMTW-1:0]  rem, rem_d;
  logic             dir, dir_d;
  logic [AMTW-1:0]  passes, passes_d;
  logic             rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_d;
  logic [AMTW-1:0]  rsp_passes_d;

  logic [SHW-1:0]   step;
  logic [AMTW-1:0]  rem_after;

  // Per-pass step is the remaining amount clipped to the barrel's range.
  always_comb begin
    if (rem > AMTW'(MAX_STEP)) begin
      step = SHW'(MAX_STEP);
    end else begin
      step = SHW'(rem);
    end
    rem_after = rem - AMTW'(step);
  end

  // Barrel inputs idle at a zero shift of the accumulator outside RUN.
  always_comb begin
    bs_in     = acc;
    bs_lr     = dir;
    bs_shift  = (state == RUN) ? step : '0;
    req_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      rem        <= '0;
      dir        <= 1'b0;
      passes     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_passes <= '0;
    end else begin
      acc        <= acc_d;
      rem        <= rem_d;
      dir        <= dir_d;
      passes     <= passes_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_passes <= rsp_passes_d;
    end
  end

  // DONE spends its first cycle loading the response registers, then waits
  // for the consumer handshake.
  always_comb begin
    state_d      = state;
    acc_d        = acc;
    rem_d        = rem;
    dir_d        = dir;
    passes_d     = passes;
    rsp_valid_d  = rsp_valid;
    rsp_data_d   = rsp_data;
    rsp_passes_d = rsp_passes;

    case (state)
      IDLE: begin
        if (req_valid) begin
          acc_d    = req_data;
          dir_d    = req_lr;
          rem_d    = req_amt;
          passes_d = '0;
          state_d  = (req_amt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d    = bs_out;
        rem_d    = rem_after;
        passes_d = passes + AMTW'(1);
        if (rem_after == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!rsp_valid) begin
          rsp_valid_d  = 1'b1;
          rsp_data_d   = acc;
          rsp_passes_d = passes;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
